// File: rtl/ddr3_arbiter_if.sv
// DDR3 arbiter bus bundle: CPU and display Avalon ports plus
// the shared controller port. slave = arbiter view.
interface ddr3_arbiter_if;
  logic        cpu_avl_ready;
  logic [23:0] cpu_avl_addr;
  logic [63:0] cpu_avl_wdata;
  logic [7:0]  cpu_avl_be;
  logic        cpu_avl_read_req;
  logic        cpu_avl_write_req;
  logic        cpu_avl_rdata_valid;
  logic [63:0] cpu_avl_rdata;

  logic        display_avl_ready;
  logic [23:0] display_avl_addr;
  logic [7:0]  display_avl_be;
  logic        display_avl_read_req;
  logic        display_avl_rdata_valid;
  logic [63:0] display_avl_rdata;

  logic        avl_ready;
  logic        avl_rdata_valid;
  logic [63:0] avl_rdata;
  logic        avl_burstbegin;
  logic [23:0] avl_addr;
  logic [63:0] avl_wdata;
  logic [7:0]  avl_be;
  logic        avl_read_req;
  logic        avl_write_req;
  logic [6:0]  avl_size;

  logic        tag_underflow;

  modport slave (
    input  cpu_avl_addr, cpu_avl_wdata, cpu_avl_be,
    input  cpu_avl_read_req, cpu_avl_write_req,
    output cpu_avl_ready, cpu_avl_rdata_valid, cpu_avl_rdata,
    input  display_avl_addr, display_avl_be,
    input  display_avl_read_req,
    output display_avl_ready, display_avl_rdata_valid,
    output display_avl_rdata,
    input  avl_ready, avl_rdata_valid, avl_rdata,
    output avl_burstbegin, avl_addr, avl_wdata, avl_be,
    output avl_read_req, avl_write_req, avl_size,
    output tag_underflow
  );

  modport master (
    output cpu_avl_addr, cpu_avl_wdata, cpu_avl_be,
    output cpu_avl_read_req, cpu_avl_write_req,
    input  cpu_avl_ready, cpu_avl_rdata_valid, cpu_avl_rdata,
    output display_avl_addr, display_avl_be,
    output display_avl_read_req,
    input  display_avl_ready, display_avl_rdata_valid,
    input  display_avl_rdata,
    output avl_ready, avl_rdata_valid, avl_rdata,
    input  avl_burstbegin, avl_addr, avl_wdata, avl_be,
    input  avl_read_req, avl_write_req, avl_size,
    input  tag_underflow
  );
endinterface

// File: rtl/ddr3_arbiter.sv
// Two-port DDR3 arbiter: display-priority with CPU starvation
// guard, and an in-order tag FIFO routing read returns.
module ddr3_arbiter #(
  parameter int MAX_DISPLAY_STREAK = 8,
  parameter int TAG_DEPTH          = 32
) (
  input logic           clk,
  input logic           reset_n,
  ddr3_arbiter_if.slave bus
);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int SW = $clog2(MAX_DISPLAY_STREAK + 1);

  logic          tags [TAG_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [SW-1:0] streak;
  logic          underflow;

  logic full, empty;
  logic cpu_req, cpu_ok, disp_ok;
  logic gnt_d, gnt_c;
  logic acc, push, pop, head;

  assign full    = (cnt == (AW+1)'(TAG_DEPTH));
  assign empty   = (cnt == '0);
  assign cpu_req = bus.cpu_avl_read_req | bus.cpu_avl_write_req;
  assign cpu_ok  = bus.cpu_avl_write_req
                 | (bus.cpu_avl_read_req & ~full);
  assign disp_ok = bus.display_avl_read_req & ~full;

  // Grants are forced low while in reset, whatever the inputs do.
  assign gnt_d = reset_n & disp_ok
               & (~cpu_req
                  | (streak < SW'(MAX_DISPLAY_STREAK)));
  assign gnt_c = reset_n & ~gnt_d & cpu_ok;

  always_comb begin
    bus.avl_read_req  = gnt_d | (gnt_c & bus.cpu_avl_read_req);
    bus.avl_write_req = gnt_c & bus.cpu_avl_write_req;
    bus.avl_addr      = '0;
    bus.avl_be        = '0;
    bus.avl_wdata     = '0;
    unique case (1'b1)
      gnt_d: begin
        bus.avl_addr = bus.display_avl_addr;
        bus.avl_be   = bus.display_avl_be;
      end
      gnt_c: begin
        bus.avl_addr  = bus.cpu_avl_addr;
        bus.avl_be    = bus.cpu_avl_be;
        bus.avl_wdata = bus.cpu_avl_wdata;
      end
      default: ;
    endcase
  end

  assign bus.avl_size       = 7'd1;
  assign bus.avl_burstbegin = bus.avl_read_req
                            | bus.avl_write_req;
  assign bus.cpu_avl_ready     = gnt_c & bus.avl_ready;
  assign bus.display_avl_ready = gnt_d & bus.avl_ready;

  assign acc  = bus.avl_ready & (gnt_c | gnt_d);
  assign push = acc & bus.avl_read_req;
  assign pop  = reset_n & bus.avl_rdata_valid & ~empty;
  assign head = tags[rd_ptr];

  assign bus.cpu_avl_rdata_valid     = pop & ~head;
  assign bus.display_avl_rdata_valid = pop & head;
  assign bus.cpu_avl_rdata           = bus.avl_rdata;
  assign bus.display_avl_rdata       = bus.avl_rdata;
  assign bus.tag_underflow           = underflow;

  always_ff @(posedge clk) begin
    if (push) tags[wr_ptr] <= gnt_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      streak    <= '0;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
      if (bus.avl_rdata_valid && empty) underflow <= 1'b1;
      if ((gnt_c && acc) || !cpu_req)
        streak <= '0;
      else if (gnt_d && acc
               && streak < SW'(MAX_DISPLAY_STREAK))
        streak <= streak + 1'b1;
    end
  end
endmodule

// File: tb/tb_ddr3_arbiter.sv
// Self-checking bench for ddr3_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_ddr3_arbiter;
  localparam int MAX   = 8;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  ddr3_arbiter_if bus();

  ddr3_arbiter #(
    .MAX_DISPLAY_STREAK(MAX),
    .TAG_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  bit m_q[$];
  int m_streak;
  bit m_uf;

  task automatic idle_inputs();
    bus.cpu_avl_addr = '0;
    bus.cpu_avl_wdata = '0;
    bus.cpu_avl_be = '0;
    bus.cpu_avl_read_req = 0;
    bus.cpu_avl_write_req = 0;
    bus.display_avl_addr = '0;
    bus.display_avl_be = '0;
    bus.display_avl_read_req = 0;
    bus.avl_ready = 0;
    bus.avl_rdata_valid = 0;
    bus.avl_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    m_q.delete();
    m_streak = 0;
    m_uf = 0;
    @(negedge clk);
  endtask

  function automatic logic [7:0] ctl_vec();
    return {bus.cpu_avl_ready, bus.display_avl_ready,
            bus.avl_read_req, bus.avl_write_req,
            bus.avl_burstbegin, bus.cpu_avl_rdata_valid,
            bus.display_avl_rdata_valid, bus.tag_underflow};
  endfunction

  task automatic test_reset();
    reset_n = 0;
    bus.cpu_avl_read_req = 1;
    bus.cpu_avl_write_req = 0;
    bus.display_avl_read_req = 1;
    bus.avl_ready = 1;
    bus.avl_rdata_valid = 1;
    bus.avl_rdata = 64'hdead_beef_0000_0001;
    #1;
    n_checks++;
    if (ctl_vec() !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctl got=%h exp=00", ctl_vec());
    end
    n_checks++;
    if (dut.cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt got=%0d exp=0", dut.cnt);
    end
    idle_inputs();
  endtask

  task automatic test_streak();
    bit exp_d;
    do_reset();
    bus.cpu_avl_read_req = 1;
    bus.display_avl_read_req = 1;
    bus.cpu_avl_addr = 24'h000100;
    bus.display_avl_addr = 24'h000200;
    bus.avl_ready = 1;
    for (int i = 0; i < 18; i++) begin
      exp_d = (i % 9) != 8;
      #1;
      n_checks++;
      if (bus.display_avl_ready !== exp_d ||
          bus.cpu_avl_ready !== !exp_d) begin
        n_fail++;
        $display("FAIL streak[%0d] got d=%b c=%b exp d=%b",
                 i, bus.display_avl_ready, bus.cpu_avl_ready,
                 exp_d);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_write();
    do_reset();
    bus.cpu_avl_addr = 24'h000010;
    bus.cpu_avl_be = 8'h0F;
    bus.cpu_avl_wdata = 64'h1122334455667788;
    bus.cpu_avl_write_req = 1;
    bus.avl_ready = 1;
    #1;
    n_checks++;
    if (bus.avl_write_req !== 1'b1 ||
        bus.avl_read_req !== 1'b0 ||
        bus.avl_burstbegin !== 1'b1 ||
        bus.avl_size !== 7'd1 ||
        bus.cpu_avl_ready !== 1'b1 ||
        bus.avl_addr !== 24'h000010 ||
        bus.avl_be !== 8'h0F ||
        bus.avl_wdata !== 64'h1122334455667788) begin
      n_fail++;
      $display("FAIL write got w=%b a=%h be=%h d=%h",
               bus.avl_write_req, bus.avl_addr, bus.avl_be,
               bus.avl_wdata);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (dut.cnt !== '0) begin
      n_fail++;
      $display("FAIL write_cnt got=%0d exp=0", dut.cnt);
    end
  endtask

  task automatic test_full();
    do_reset();
    bus.display_avl_read_req = 1;
    bus.display_avl_addr = 24'h00abcd;
    bus.avl_ready = 1;
    repeat (DEPTH) @(negedge clk);
    bus.cpu_avl_write_req = 1;
    bus.cpu_avl_wdata = 64'h55;
    #1;
    n_checks++;
    if (bus.display_avl_ready !== 1'b0 ||
        bus.cpu_avl_ready !== 1'b1 ||
        bus.avl_write_req !== 1'b1) begin
      n_fail++;
      $display("FAIL full_block got d=%b c=%b w=%b exp 0 1 1",
               bus.display_avl_ready, bus.cpu_avl_ready,
               bus.avl_write_req);
    end
    @(negedge clk);
    bus.cpu_avl_write_req = 0;
    bus.avl_rdata_valid = 1;
    bus.avl_rdata = 64'hcafe_f00d_1234_5678;
    #1;
    n_checks++;
    if (bus.display_avl_rdata_valid !== 1'b1 ||
        bus.display_avl_rdata !== 64'hcafe_f00d_1234_5678 ||
        bus.display_avl_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop got v=%b r=%b exp v=1 r=0",
               bus.display_avl_rdata_valid,
               bus.display_avl_ready);
    end
    @(negedge clk);
    bus.avl_rdata_valid = 0;
    #1;
    n_checks++;
    if (bus.display_avl_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_resume got=%b exp=1",
               bus.display_avl_ready);
    end
    idle_inputs();
  endtask

  task automatic test_order();
    logic [63:0] d [3];
    bit exp_c [3] = '{1'b1, 1'b0, 1'b1};
    do_reset();
    bus.avl_ready = 1;
    bus.cpu_avl_read_req = 1;
    @(negedge clk);
    bus.cpu_avl_read_req = 0;
    bus.display_avl_read_req = 1;
    @(negedge clk);
    bus.display_avl_read_req = 0;
    bus.cpu_avl_read_req = 1;
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      d[i] = {$urandom, $urandom};
      bus.avl_rdata_valid = 1;
      bus.avl_rdata = d[i];
      #1;
      n_checks++;
      if (bus.cpu_avl_rdata_valid !== exp_c[i] ||
          bus.display_avl_rdata_valid !== !exp_c[i] ||
          bus.cpu_avl_rdata !== d[i] ||
          bus.display_avl_rdata !== d[i]) begin
        n_fail++;
        $display("FAIL order[%0d] got c=%b d=%b exp c=%b",
                 i, bus.cpu_avl_rdata_valid,
                 bus.display_avl_rdata_valid, exp_c[i]);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_underflow();
    do_reset();
    bus.avl_rdata_valid = 1;
    #1;
    n_checks++;
    if (bus.cpu_avl_rdata_valid !== 1'b0 ||
        bus.display_avl_rdata_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_valid got c=%b d=%b exp 0 0",
               bus.cpu_avl_rdata_valid,
               bus.display_avl_rdata_valid);
    end
    @(negedge clk);
    bus.avl_rdata_valid = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.tag_underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL uf_sticky got=%b exp=1", bus.tag_underflow);
    end
    reset_n = 0;
    #1;
    n_checks++;
    if (bus.tag_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_clear got=%b exp=0", bus.tag_underflow);
    end
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.avl_ready = 1;
    bus.cpu_avl_read_req = 1;
    repeat (5) @(negedge clk);
    bus.display_avl_read_req = 1;
    bus.avl_rdata_valid = 1;
    reset_n = 0;
    #1;
    n_checks++;
    if (ctl_vec() !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset_ctl got=%h exp=00", ctl_vec());
    end
    @(negedge clk);
    idle_inputs();
    reset_n = 1;
    #1;
    n_checks++;
    if (dut.cnt !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_cnt got=%0d exp=0", dut.cnt);
    end
    @(negedge clk);
    bus.avl_rdata_valid = 1;
    #1;
    n_checks++;
    if (bus.cpu_avl_rdata_valid !== 1'b0 ||
        bus.display_avl_rdata_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_ret got c=%b d=%b exp 0 0",
               bus.cpu_avl_rdata_valid,
               bus.display_avl_rdata_valid);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (bus.tag_underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_uf got=%b exp=1",
               bus.tag_underflow);
    end
  endtask

  task automatic test_random();
    bit rd, wr, drd, rdy, rv;
    bit full, creq, c_el, d_el, gd, gc, acc;
    bit ev_c, ev_d;
    logic [103:0] got, exp;
    int errs = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int sel = $urandom_range(0, 2);
      rd  = (sel == 1);
      wr  = (sel == 2);
      drd = $urandom_range(0, 1);
      rdy = $urandom_range(0, 3) != 0;
      rv  = (i < 300) ? ($urandom_range(0, 3) == 0)
                      : ($urandom_range(0, 3) != 0);
      bus.cpu_avl_read_req = rd;
      bus.cpu_avl_write_req = wr;
      bus.cpu_avl_addr = 24'($urandom);
      bus.cpu_avl_be = 8'($urandom);
      bus.cpu_avl_wdata = {$urandom, $urandom};
      bus.display_avl_read_req = drd;
      bus.display_avl_addr = 24'($urandom);
      bus.display_avl_be = 8'($urandom);
      bus.avl_ready = rdy;
      bus.avl_rdata_valid = rv;
      bus.avl_rdata = {$urandom, $urandom};

      full = m_q.size() >= DEPTH;
      creq = rd || wr;
      c_el = wr || (rd && !full);
      d_el = drd && !full;
      gd = d_el && (!creq || m_streak < MAX);
      gc = !gd && c_el;
      acc = rdy && (gd || gc);
      ev_c = rv && m_q.size() > 0 && m_q[0] == 1'b0;
      ev_d = rv && m_q.size() > 0 && m_q[0] == 1'b1;
      exp = {gc && rdy, gd && rdy, gd || (gc && rd),
             gc && wr, gd || gc,
             gd ? bus.display_avl_addr
                : (gc ? bus.cpu_avl_addr : 24'h0),
             gc ? bus.cpu_avl_wdata : 64'h0,
             gd ? bus.display_avl_be
                : (gc ? bus.cpu_avl_be : 8'h0),
             ev_c, ev_d, m_uf};
      #1;
      got = {bus.cpu_avl_ready, bus.display_avl_ready,
             bus.avl_read_req, bus.avl_write_req,
             bus.avl_burstbegin, bus.avl_addr, bus.avl_wdata,
             bus.avl_be, bus.cpu_avl_rdata_valid,
             bus.display_avl_rdata_valid, bus.tag_underflow};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        if (errs++ < 10)
          $display("FAIL random[%0d] got=%h exp=%h", i, got, exp);
      end

      if (rv) begin
        if (m_q.size() == 0) m_uf = 1;
        else void'(m_q.pop_front());
      end
      if (acc && (gd || rd)) m_q.push_back(gd);
      if ((gc && acc) || !creq) m_streak = 0;
      else if (gd && acc && m_streak < MAX) m_streak++;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_streak();
    test_write();
    test_full();
    test_order();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ddr3_arbiter.md
DDR3_ARBITER -- requirements
Module: ddr3_arbiter

Interface
REQ-001 Parameter MAX_DISPLAY_STREAK, default 8: consecutive display grants allowed while CPU waits.
REQ-002 Parameter TAG_DEPTH, default 32, power of two: read-return tag FIFO entries.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  in  1  system clock.
REQ-005 Port: reset_n  in  1  asynchronous active-low reset.
REQ-006 Port: cpu_avl_ready  out  1  CPU request accepted this cycle if asserted.
REQ-007 Port: cpu_avl_addr  in  24  CPU 64-bit word address.
REQ-008 Port: cpu_avl_wdata / cpu_avl_be  in  64 / 8  CPU write data, byte enables.
REQ-009 Port: cpu_avl_read_req / cpu_avl_write_req  in  1 / 1  CPU requests, mutually exclusive.
REQ-010 Port: cpu_avl_rdata_valid / cpu_avl_rdata  out  1 / 64  CPU read return.
REQ-011 Port: display_avl_ready  out  1  display read accepted this cycle.
REQ-012 Port: display_avl_addr / display_avl_be / display_avl_read_req  in  24 / 8 / 1  display read request.
REQ-013 Port: display_avl_rdata_valid / display_avl_rdata  out  1 / 64  display read return.
REQ-014 Port: avl_ready / avl_rdata_valid / avl_rdata  in  1 / 1 / 64  controller side.
REQ-015 Port: avl_burstbegin, avl_addr[24], avl_wdata[64], avl_be[8], avl_read_req, avl_write_req, avl_size[7]  out  controller request.
REQ-016 Port: tag_underflow  out  1  sticky error: return data with no outstanding read.

Function
REQ-017 Grant is combinational each cycle: display if display_avl_read_req and (no CPU request or streak < MAX_DISPLAY_STREAK), else CPU if requesting, else none.
REQ-018 Streak counter increments on each accepted display read while a CPU request is pending, clears on any accepted CPU request, clears when no CPU request pending; saturates at MAX_DISPLAY_STREAK.
REQ-019 A read is eligible only when the tag FIFO is not full; an ineligible read is not granted and the other requester may be granted instead.
REQ-020 Downstream fields mirror the granted requester; avl_read_req/avl_write_req = granted request; all zero when no grant; display grant drives avl_write_req=0, avl_wdata=0.
REQ-021 avl_size is constant 1; avl_burstbegin equals (avl_read_req | avl_write_req).
REQ-022 Acceptance = avl_ready & (avl_read_req | avl_write_req); only granted requester's *_avl_ready is asserted, equal to avl_ready; the other is 0.
REQ-023 On accepted read, push tag (0=CPU, 1=display) into FIFO in that cycle; accepted writes push nothing.
REQ-024 On avl_rdata_valid, pop head tag and route: same-cycle assert cpu_ or display_avl_rdata_valid with avl_rdata; zero combinational latency on return path.
REQ-025 Both *_avl_rdata outputs always carry avl_rdata; only the valid bits differ.
REQ-026 Simultaneous push and pop allowed at any occupancy, including full (pop frees slot only next cycle: full blocks new reads in that cycle); count unchanged.
REQ-027 Pointers wrap modulo TAG_DEPTH; occupancy counter width log2(TAG_DEPTH)+1.
REQ-028 avl_rdata_valid with empty FIFO: no requester valid asserted, tag_underflow set and held until reset.
REQ-029 Requests are not registered: requester holds request stable until its ready is seen with request.

Reset
REQ-030 While reset_n low: FIFO empty, pointers 0, streak 0, tag_underflow 0; all valid/req/ready outputs 0 regardless of inputs.
REQ-031 Reset mid-operation discards outstanding tags; returns arriving after release count as underflow.

Verification
REQ-032 Both request reads, avl_ready=1 continuous, MAX_DISPLAY_STREAK=8 -> 8 display grants, then 1 CPU grant, pattern repeats.
REQ-033 CPU write addr 0x000010, be 0x0F, data 0x1122334455667788 alone -> avl_write_req=1 same cycle with identical fields, FIFO count stays 0.
REQ-034 Issue 32 display reads with no return -> FIFO full, display_avl_ready 0, CPU write still granted; one return -> reads resume next cycle.
REQ-035 Interleaved CPU, display, CPU reads; returns D0,D1,D2 -> cpu valid, display valid, cpu valid in order, each same cycle as avl_rdata_valid.
REQ-036 avl_rdata_valid pulse after reset with no reads -> no requester valid, tag_underflow=1 until reset_n low.
REQ-037 Assert reset_n low with 5 reads outstanding, avl_ready=1 -> all outputs 0 during reset, count 0 after release.
